// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
//   state_e      : FSM state encoding (IDLE, RUN, DONE)
//   NIBBLE       : bits processed per clock by the lookahead slice
//   num_nibbles  : number of nibbles N in an operand of a given width
package sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIBBLE = 4;

   function automatic int num_nibbles(input int width);
      return width / NIBBLE;
   endfunction

endpackage

// File: rtl/nibble_serial_subtractor_cla4_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder slice.
// Ports:
//   x[3:0], y[3:0] : addend nibbles
//   cin            : carry in
//   sum[3:0]       : x + y + cin, low four bits
//   cout           : carry out of bit 3
module cla4_slice (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   logic [3:0] p;
   logic [3:0] g;
   logic [4:1] c;

   assign p = x ^ y;
   assign g = x & y;

   // Flat two-level carries: every carry is a sum of products of p, g and cin.
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum  = p ^ {c[3:1], cin};
   assign cout = c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: computes diff = a - b one nibble per clock as
// a + ~b + 1 through a single cla4_slice, carry registered between nibbles.
// Optional feature macro: SUB_ZERO_FLAG_EN (adds the zero output).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b latched on acceptance)
//   a, b                : minuend, subtrahend (WIDTH bits)
//   out_valid/out_ready : result handshake
//   diff                : (a - b) mod 2^WIDTH
//   borrow              : a < b unsigned
//   overflow            : signed overflow of a - b
//   zero                : diff == 0 (only with SUB_ZERO_FLAG_EN)
module nibble_serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             overflow
`ifdef SUB_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int N  = num_nibbles(WIDTH);
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   state_e                 state_q, state_d;
   logic [KW-1:0]          k_q, k_d;
   logic                   carry_q, carry_d;
   logic [N-1:0][3:0]      a_q, a_d;
   logic [N-1:0][3:0]      nb_q, nb_d;
   logic [N-1:0][3:0]      diff_q, diff_d;
   logic                   borrow_q, borrow_d;
   logic                   ovf_q, ovf_d;
`ifdef SUB_ZERO_FLAG_EN
   logic                   zacc_q, zacc_d;
   logic                   zero_q, zero_d;
`endif

   logic [3:0] s;
   logic       c;
   logic       last;

   cla4_slice u_slice (
      .x   (a_q[k_q]),
      .y   (nb_q[k_q]),
      .cin (carry_q),
      .sum (s),
      .cout(c)
   );

   assign last = (k_q == KW'(N - 1));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (in_valid)  state_d = RUN;
         RUN:     if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // State-decoded handshake outputs
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // Datapath next-state
   always_comb begin
      a_d      = a_q;
      nb_d     = nb_q;
      diff_d   = diff_q;
      carry_d  = carry_q;
      k_d      = k_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
      zacc_d   = zacc_q;
      zero_d   = zero_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // Subtraction as a + ~b + 1: the +1 enters as the initial carry.
               a_d      = a;
               nb_d     = ~b;
               diff_d   = '0;
               carry_d  = 1'b1;
               k_d      = '0;
               borrow_d = 1'b0;
               ovf_d    = 1'b0;
`ifdef SUB_ZERO_FLAG_EN
               zacc_d   = 1'b1;
               zero_d   = 1'b0;
`endif
            end
         end
         RUN: begin
            diff_d[k_q] = s;
            carry_d     = c;
            k_d         = last ? '0 : k_q + 1'b1;
`ifdef SUB_ZERO_FLAG_EN
            zacc_d      = zacc_q & (s == 4'd0);
`endif
            if (last) begin
               borrow_d = ~c;
               // Operand signs differ (b's sign is the inverse of the latched ~b)
               // and the result sign departs from a's sign.
               ovf_d    = (a_q[N-1][3] ^ ~nb_q[N-1][3]) & (s[3] ^ a_q[N-1][3]);
`ifdef SUB_ZERO_FLAG_EN
               zero_d   = zacc_q & (s == 4'd0);
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         nb_q     <= '0;
         diff_q   <= '0;
         carry_q  <= 1'b1;
         k_q      <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
`ifdef SUB_ZERO_FLAG_EN
         zacc_q   <= 1'b1;
         zero_q   <= 1'b0;
`endif
      end else begin
         a_q      <= a_d;
         nb_q     <= nb_d;
         diff_q   <= diff_d;
         carry_q  <= carry_d;
         k_q      <= k_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
`ifdef SUB_ZERO_FLAG_EN
         zacc_q   <= zacc_d;
         zero_q   <= zero_d;
`endif
      end
   end

   assign diff     = diff_q;
   assign borrow   = borrow_q;
   assign overflow = ovf_q;
`ifdef SUB_ZERO_FLAG_EN
   assign zero     = zero_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
module tb_nibble_serial_subtractor;

   localparam int W = 16;
   localparam int N = W / 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] diff;
   logic         borrow;
   logic         overflow;
`ifdef SUB_ZERO_FLAG_EN
   logic         zero;
`endif

   int checks = 0;
   int errors = 0;

   nibble_serial_subtractor #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .borrow   (borrow),
      .overflow (overflow)
`ifdef SUB_ZERO_FLAG_EN
      ,
      .zero     (zero)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the full operands.
   task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                          output logic [W-1:0] d, output logic bo, output logic ov);
      longint ua, ub, sa, sb, sd, smax, smin;
      ua   = longint'(ra);
      ub   = longint'(rb);
      sa   = longint'($signed(ra));
      sb   = longint'($signed(rb));
      sd   = sa - sb;
      smax = (longint'(1) << (W - 1)) - 1;
      smin = -(longint'(1) << (W - 1));
      d    = W'(ua - ub);
      bo   = (ua < ub);
      ov   = (sd > smax) || (sd < smin);
   endtask

   task automatic wait_in_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check("in_ready_timeout", 64'(in_ready), 64'd1);
   endtask

   // Accept one operand pair, check latency and result, leave DUT in DONE.
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
      int lat;
      logic [W-1:0] ed;
      logic eb, eo;
      ref_sub(ta, tb_v, ed, eb, eo);
      wait_in_ready();
      a = ta; b = tb_v; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom);
      check("in_ready_run", 64'(in_ready), 64'd0);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1; lat++;
      end
      check("latency", 64'(lat), 64'(N));
      check("diff", 64'(diff), 64'(ed));
      check("borrow", 64'(borrow), 64'(eb));
      check("overflow", 64'(overflow), 64'(eo));
      check("in_ready_done", 64'(in_ready), 64'd0);
`ifdef SUB_ZERO_FLAG_EN
      check("zero", 64'(zero), 64'(ed == '0));
`endif
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("out_valid_after_hs", 64'(out_valid), 64'd0);
      check("in_ready_after_hs", 64'(in_ready), 64'd1);
   endtask

   initial begin
      logic [W-1:0] hold_d;
      logic         hold_b, hold_o;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_diff", 64'(diff), 64'd0);
      check("rst_borrow", 64'(borrow), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Reset in the middle of RUN
      a = 16'h1234; b = 16'h0001; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_diff", 64'(diff), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(16'h0005, 16'h0003); release_result();

      // Directed cases
      issue(16'h1234, 16'h0234); release_result();
      issue(16'h0000, 16'h0001); release_result();
      issue(16'h8000, 16'h0001); release_result();
      issue(16'h7FFF, 16'hFFFF); release_result();
      issue(16'hABCD, 16'hABCD); release_result();
      issue(16'hABCD, 16'hABCC); release_result();
      issue(16'h5A5A, 16'h0000); release_result();

      // Backpressure: result must hold while out_ready stays low
      issue(16'h4321, 16'h1234);
      hold_d = diff; hold_b = borrow; hold_o = overflow;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = W'($urandom); b = W'($urandom);
         @(posedge clk); #1;
         check("bp_out_valid", 64'(out_valid), 64'd1);
         check("bp_in_ready", 64'(in_ready), 64'd0);
         check("bp_diff", 64'(diff), 64'(hold_d));
         check("bp_flags", 64'({borrow, overflow}), 64'({hold_b, hold_o}));
      end
      in_valid = 1'b0;
      release_result();
      @(posedge clk); #1;
      check("bp_idle_stays", 64'({in_ready, out_valid}), 64'b10);

      // Randomized regression, results consumed immediately
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         ra = W'($urandom);
         rb = W'($urandom);
         if (i % 8 == 0) rb = ra;
         issue(ra, rb);
         release_result();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle unsigned/two's-complement subtractor computing `diff = a - b` one 4-bit nibble per clock through a single 4-bit carry-lookahead slice, with a registered carry between nibbles. It is the subtract-direction counterpart of the team's 4-bit lookahead adder and serves datapaths that trade latency for area. Operands enter and the result leaves through independent valid/ready handshakes.

## Interface

- `WIDTH`, default 16: operand width in bits; must be a multiple of 4 and at least 4; `N = WIDTH/4` nibbles.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `in_valid  in  1`: operand pair `a`/`b` is valid.
- `in_ready  out  1`: block can accept operands.
- `a  in  WIDTH`: minuend.
- `b  in  WIDTH`: subtrahend.
- `out_valid  out  1`: result fields are valid.
- `out_ready  in  1`: consumer accepts the result.
- `diff  out  WIDTH`: `(a - b) mod 2^WIDTH`.
- `borrow  out  1`: 1 when `a < b` unsigned, equal to the inverted final carry.
- `overflow  out  1`: signed overflow, set when `a[MSB] != b[MSB]` and `diff[MSB] != a[MSB]`.

## Operation

- FSM states are `IDLE`, `RUN`, and `DONE`. Reset forces `IDLE`, nibble index `k=0`, carry register `1`, `in_ready=1`, `out_valid=0`, `diff=0`, `borrow=0`, `overflow=0` (and `zero=0` if configured).
- **IDLE:** `in_ready=1`. On `in_valid & in_ready`:
  - latch `a`;
  - latch `~b`;
  - clear the result register;
  - set carry to `1`;
  - set `k=0`;
  - go to `RUN`.
- **RUN:** `in_ready=0`. Each cycle:
  - feed nibble `k` of latched `a` and `~b`, plus the carry register, to the slice;
  - write the slice sum to `diff[4k+3:4k]`;
  - write the slice carry-out to the carry register;
  - increment `k`.
- **RUN, after nibble `N-1`:** compute `borrow = ~carry_out` and `overflow`, then go to `DONE`.
- **DONE:** `out_valid=1`. Outputs hold stable until `out_ready`. On `out_valid & out_ready`, go to `IDLE`.
- No bypass: a new input is never accepted in the same cycle as a result handshake, since `in_ready` is low in `DONE`.
- `diff` is updated only in `RUN`. The value shown in `IDLE` is the last result, or 0 after reset, and is don't-care to the consumer.
- Operands changing while `in_ready=0` are ignored, because operands are latched at acceptance.
- Reset asserted in any state aborts the operation immediately and restores all reset values. A partial result is never presented.
- Edge cases:
  - `a == b` gives `diff=0`, `borrow=0`, `overflow=0`.
  - `b=0` gives `diff=a`, `borrow=0`.

## Timing

- Acceptance edge `T`: nibbles are processed on edges `T+1 … T+N`.
- `out_valid` rises after edge `T+N`. Latency from accept to `out_valid` is `N` cycles (4 for the default width).
- Minimum issue interval is `N+2` cycles (`RUN`, one `DONE` cycle with immediate `out_ready`, one `IDLE` accept).
- `out_ready` held low stalls indefinitely in `DONE` with no state change.
- `in_ready`, `out_valid`, and all result outputs are registered or state-decoded. There is no combinational path from `in_valid` or `out_ready` to any output.

## Configuration

- `SUB_ZERO_FLAG_EN`:
  - **Defined:** adds output port `zero out 1`, which is 1 in `DONE` when `diff == 0`. It is accumulated per nibble (AND of "nibble sum == 0") without a wide comparator. It resets to 0 and is cleared at acceptance.
  - **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Structure

- Shared package `sub_pkg`:
  - FSM state enum `{IDLE, RUN, DONE}`;
  - constant `NIBBLE = 4`;
  - a function giving `N` from `WIDTH`.
- One sub-module, `cla4_slice`:
  - combinational 4-bit lookahead slice;
  - inputs `x[3:0]`, `y[3:0]`, `cin`;
  - outputs `sum[3:0]` and `cout`;
  - internal per-bit `p = x ^ y` and `g = x & y`, with flat two-level lookahead carries.
- The top level holds the FSM, operand and result registers, carry register, nibble counter, and flags.

## Test plan

- Reset mid-`RUN`: accept `a=0x1234`, `b=0x0001`, assert `rst` after 2 cycles → `out_valid=0`, `in_ready=1`, `diff=0` immediately. A subsequent `0x0005-0x0003` → `diff=0x0002`.
- Basic subtract: `a=0x1234`, `b=0x0234`, `out_ready=1` → `out_valid` 4 cycles after accept, `diff=0x1000`, `borrow=0`, `overflow=0`.
- Underflow: `a=0x0000`, `b=0x0001` → `diff=0xFFFF`, `borrow=1`, `overflow=0`. Cross-nibble carry chain verified.
- Signed overflow: `a=0x8000`, `b=0x0001` → `diff=0x7FFF`, `borrow=0`, `overflow=1`. Also `a=0x7FFF`, `b=0xFFFF` → `diff=0x8000`, `borrow=1`, `overflow=1`.
- Backpressure: hold `out_ready=0` for 10 cycles in `DONE`, toggling `in_valid` and `a`/`b` → `diff` and flags stable, `in_ready=0`. Release → single handshake, then `IDLE`.
- `SUB_ZERO_FLAG_EN`: `a=b=0xABCD` → `zero=1`. `a=0xABCD`, `b=0xABCC` → `zero=0`, `diff=0x0001`. Random back-to-back regression against a reference model at `WIDTH=4`, 16, and 32.
